// File: rtl/arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states, read owner, counter sizing.
package arb_pkg;

    typedef enum logic {IDLE, RD_BUSY} arb_state_t;
    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

    localparam int MAX_RD_LAT = 4;

    // Counter width able to hold the value lat (LAT_W = $clog2(RD_LAT+1)).
    function automatic int lat_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rd_lat_tracker.sv
// Tracks the one outstanding RAM read: latency count, owner, flush-kill bit,
// captured read data and the per-requester rvalid pulses.
module rd_lat_tracker
    import arb_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              start,
    input  arb_owner_t        start_owner,
    input  logic              flush,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              done,
    output logic              if_pend,
    output logic              mem_pend,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = lat_width(RD_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0] LAT_CAP  = LAT_W'(RD_LAT - 1);

    logic [LAT_W-1:0]  cnt;
    arb_owner_t        owner;
    logic              kill;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] mem_hold;
    logic              capture;

    assign done       = busy && (cnt == LAT_LAST);
    assign if_pend    = busy && (owner == OWN_IF) && !kill;
    assign mem_pend   = busy && (owner == OWN_MEM);
    assign if_rvalid  = done && (owner == OWN_IF) && !kill && !flush;
    assign mem_rvalid = done && (owner == OWN_MEM);

    // Data is sampled on the edge that ends the cycle before rvalid, so it is
    // already registered when the pulse fires.
    assign capture = (start && (RD_LAT == 1)) || (busy && !done && (cnt == LAT_CAP));

    assign if_rdata  = if_rvalid  ? cap : if_hold;
    assign mem_rdata = mem_rvalid ? cap : mem_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            owner    <= OWN_IF;
            kill     <= 1'b0;
            cap      <= '0;
            if_hold  <= '0;
            mem_hold <= '0;
        end else begin
            if (start) begin
                cnt   <= LAT_W'(1);
                owner <= start_owner;
                kill  <= 1'b0;
            end else begin
                if (busy && !done)
                    cnt <= cnt + LAT_W'(1);
                else if (done)
                    cnt <= '0;
                if (flush && busy && (owner == OWN_IF))
                    kill <= 1'b1;
            end
            if (capture)
                cap <= ram_rdata;
            if (if_rvalid)
                if_hold <= cap;
            if (mem_rvalid)
                mem_hold <= cap;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (read-only)
// and the memory stage (read/write), with MEM priority and an IF anti-starvation streak.
module shared_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 24,
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              if_stall,
    output logic              mem_stall
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    arb_state_t          state;
    logic [STREAK_W-1:0] streak;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                done;
    logic                if_pend;
    logic                mem_pend;
    logic                grant_window;
    logic                give_if;
    logic                give_mem;
    logic                rd_start;

    // The last busy cycle also grants so reads can issue back to back.
    assign grant_window = (state == IDLE) || done;
    assign give_if      = grant_window && if_req && !flush && (!mem_req || (streak == STREAK_MAX));
    assign give_mem     = grant_window && mem_req && !give_if;
    assign rd_start     = give_if || (give_mem && !mem_we);

    assign if_gnt    = give_if;
    assign mem_gnt   = give_mem;
    assign ram_addr  = give_mem ? mem_addr : (give_if ? if_addr : addr_q);
    assign ram_we    = give_mem && mem_we;
    assign ram_wdata = give_mem ? mem_wdata : wdata_q;

    // A flushed fetch no longer needs to hold the IF stage.
    assign if_stall  = !flush && ((if_req && !if_gnt) || (if_pend && !if_rvalid));
    assign mem_stall = (mem_req && !mem_gnt) || (mem_pend && !mem_rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            streak  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (rd_start)
                state <= RD_BUSY;
            else if (done)
                state <= IDLE;
            // Saturates so a flushed IF cannot push the streak past its limit.
            if (give_if || !if_req)
                streak <= '0;
            else if (give_mem && (streak != STREAK_MAX))
                streak <= streak + STREAK_W'(1);
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
        end
    end

    rd_lat_tracker #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .busy        (state == RD_BUSY),
        .start       (rd_start),
        .start_owner (give_mem ? OWN_MEM : OWN_IF),
        .flush       (flush),
        .ram_rdata   (ram_rdata),
        .done        (done),
        .if_pend     (if_pend),
        .mem_pend    (mem_pend),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: RD_LAT=1 instance driven from a vector table with a read-data
// scoreboard, plus an RD_LAT=2 instance for flush-during-busy and mid-read reset sequences.
module tb_shared_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        if_req = 0, mem_req = 0, mem_we = 0, flush = 0;
    logic [15:0] if_addr = 0, mem_addr = 0;
    logic [23:0] mem_wdata = 0;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_we, if_stall, mem_stall;
    logic [23:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;

    logic        if_req2 = 0, mem_req2 = 0, mem_we2 = 0, flush2 = 0;
    logic [15:0] if_addr2 = 0, mem_addr2 = 0;
    logic [23:0] mem_wdata2 = 0;
    logic        if_gnt2, if_rvalid2, mem_gnt2, mem_rvalid2, ram_we2, if_stall2, mem_stall2;
    logic [23:0] if_rdata2, mem_rdata2, ram_wdata2;
    logic [23:0] ram_rdata2 = 0;
    logic [15:0] ram_addr2;

    logic [23:0] mem   [0:65535];
    logic [23:0] model [0:255];
    logic [23:0] if_q[$];
    logic [23:0] mem_q[$];

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [23:0] mem_wdata;
        logic        flush;
        logic [5:0]  exp;
        logic        push_if;
        logic        push_mem;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    shared_mem_arbiter #(.ADDR_W(16), .DATA_W(24), .RD_LAT(1), .MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    shared_mem_arbiter #(.ADDR_W(16), .DATA_W(24), .RD_LAT(2), .MAX_STREAK(4)) dut2 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2), .if_gnt(if_gnt2), .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_gnt(mem_gnt2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2), .flush(flush2),
        .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
        .if_stall(if_stall2), .mem_stall(mem_stall2)
    );

    // RAM for the RD_LAT=1 instance reads combinationally; the RD_LAT=2 one adds one register stage.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata2 <= mem[ram_addr2];
    end

    function automatic logic [23:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 'h10) ? 24'hABCDEF : {8'hC3, b, ~b};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [15:0] ia, input logic mr, input logic mw,
                       input logic [15:0] ma, input logic [23:0] md, input logic fl,
                       input logic [5:0] exp, input logic pi, input logic pm);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.mem_req = mr; v.mem_we = mw; v.mem_addr = ma;
        v.mem_wdata = md; v.flush = fl; v.exp = exp; v.push_if = pi; v.push_mem = pm;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        if_req = v.if_req; if_addr = v.if_addr; mem_req = v.mem_req; mem_we = v.mem_we;
        mem_addr = v.mem_addr; mem_wdata = v.mem_wdata; flush = v.flush;
        if (v.push_if)
            if_q.push_back(model[v.if_addr[7:0]]);
        if (v.push_mem)
            mem_q.push_back(model[v.mem_addr[7:0]]);
        if (v.mem_req && v.mem_we && v.exp[4])
            model[v.mem_addr[7:0]] = v.mem_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read-data scoreboard for the RD_LAT=1 instance.
    always @(negedge clk) begin
        if (rst && if_rvalid) begin
            if (if_q.size() == 0)
                check_output("if_rvalid_unexpected", 1, 0);
            else
                check_output("if_rdata", {8'h0, if_rdata}, {8'h0, if_q.pop_front()});
        end
        if (rst && mem_rvalid) begin
            if (mem_q.size() == 0)
                check_output("mem_rvalid_unexpected", 1, 0);
            else
                check_output("mem_rdata", {8'h0, mem_rdata}, {8'h0, mem_q.pop_front()});
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] <= init_val(i);
            model[i] = init_val(i);
        end

        // Vector columns of exp: {if_gnt, mem_gnt, if_rvalid, mem_rvalid, if_stall, mem_stall}
        add(1, 'h10, 0, 0, 0, 0, 0, 6'b100000, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
        add(1, 'h20, 1, 1, 'h20, 'h123456, 0, 6'b010010, 0, 0);
        add(1, 'h20, 0, 0, 0, 0, 0, 6'b100000, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
        add(1, 'h40, 1, 0, 'h30, 0, 0, 6'b010010, 0, 1);
        add(1, 'h40, 1, 0, 'h31, 0, 0, 6'b010110, 0, 1);
        add(1, 'h40, 1, 0, 'h32, 0, 0, 6'b010110, 0, 1);
        add(1, 'h40, 1, 0, 'h33, 0, 0, 6'b010110, 0, 1);
        add(1, 'h40, 1, 0, 'h34, 0, 0, 6'b100101, 1, 0);
        add(0, 0, 1, 0, 'h34, 0, 0, 6'b011000, 0, 1);
        add(1, 'h41, 1, 0, 'h35, 0, 0, 6'b010110, 0, 1);
        add(1, 'h41, 0, 0, 0, 0, 0, 6'b100100, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, 16'(i), 0, 0, 0, 0, 0, {2'b10, (i != 0), 3'b000}, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0);
        add(1, 'h10, 0, 0, 0, 0, 0, 6'b100000, 0, 0);
        add(1, 'h11, 0, 0, 0, 0, 1, 6'b000000, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);

        // Reset state
        #12;
        check_output("rst_if_gnt", if_gnt, 0);
        check_output("rst_if_rvalid", if_rvalid, 0);
        check_output("rst_if_rdata", if_rdata, 0);
        check_output("rst_ram_we", ram_we, 0);
        check_output("rst_ram_addr", ram_addr, 0);
        check_output("rst_if_stall", if_stall, 0);
        step();
        rst = 1'b1;

        foreach (vecs[i]) begin
            step();
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].exp[5]);
            check_output($sformatf("v%0d_mem_gnt", i), mem_gnt, vecs[i].exp[4]);
            check_output($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].exp[3]);
            check_output($sformatf("v%0d_mem_rvalid", i), mem_rvalid, vecs[i].exp[2]);
            check_output($sformatf("v%0d_if_stall", i), if_stall, vecs[i].exp[1]);
            check_output($sformatf("v%0d_mem_stall", i), mem_stall, vecs[i].exp[0]);
        end
        step();
        if_req = 0; mem_req = 0; mem_we = 0; flush = 0;

        // Flush one cycle after an IF grant with RD_LAT=2; MEM is granted as the dropped read ends.
        step();
        if_req2 = 1; if_addr2 = 'h10;
        @(negedge clk);
        check_output("f_if_gnt", if_gnt2, 1);
        step();
        if_req2 = 0; flush2 = 1; mem_req2 = 1; mem_we2 = 0; mem_addr2 = 'h30;
        @(negedge clk);
        check_output("f_mem_gnt_busy", mem_gnt2, 0);
        check_output("f_mem_stall_busy", mem_stall2, 1);
        check_output("f_if_stall_flush", if_stall2, 0);
        check_output("f_if_rvalid_1", if_rvalid2, 0);
        step();
        flush2 = 0;
        @(negedge clk);
        check_output("f_if_rvalid_2", if_rvalid2, 0);
        check_output("f_mem_gnt_end", mem_gnt2, 1);
        check_output("f_if_stall_killed", if_stall2, 0);
        step();
        mem_req2 = 0;
        @(negedge clk);
        check_output("f_mem_rvalid_early", mem_rvalid2, 0);
        check_output("f_mem_stall_pend", mem_stall2, 1);
        step();
        @(negedge clk);
        check_output("f_mem_rvalid", mem_rvalid2, 1);
        check_output("f_mem_rdata", mem_rdata2, model['h30]);
        check_output("f_mem_stall_done", mem_stall2, 0);

        // Asynchronous reset while an IF read is in flight.
        step();
        if_req2 = 1; if_addr2 = 'h11;
        @(negedge clk);
        check_output("r_if_gnt", if_gnt2, 1);
        step();
        if_req2 = 0;
        @(negedge clk);
        check_output("r_if_stall_pend", if_stall2, 1);
        #2;
        rst = 1'b0;
        #1;
        check_output("r_if_stall", if_stall2, 0);
        check_output("r_mem_stall", mem_stall2, 0);
        check_output("r_if_rvalid", if_rvalid2, 0);
        check_output("r_mem_rdata2", mem_rdata2, 0);
        check_output("r_ram_addr2", ram_addr2, 0);
        check_output("r_ram_we2", ram_we2, 0);
        check_output("r_ram_wdata2", ram_wdata2, 0);
        check_output("r_if_rdata", if_rdata, 0);
        check_output("r_mem_rdata", mem_rdata, 0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("r_stray_%0d", i), if_rvalid2 | mem_rvalid2, 0);
            step();
        end
        mem_req2 = 1; mem_we2 = 0; mem_addr2 = 'h31;
        @(negedge clk);
        check_output("r_first_gnt", mem_gnt2, 1);
        step();
        mem_req2 = 0;
        @(negedge clk);
        check_output("r_rvalid_early", mem_rvalid2, 0);
        step();
        @(negedge clk);
        check_output("r_rvalid", mem_rvalid2, 1);
        check_output("r_rdata", mem_rdata2, model['h31]);

        step();
        check_output("if_q_drained", if_q.size(), 0);
        check_output("mem_q_drained", mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
